gsim_matvec: RTL and testbench

Streaming banded matrix-vector multiplier: the inverse direction of the GSIM solver. It consumes a 16-element solution vector x in the same stream format GSIM emits (`out_valid`/`x_out`, signed Q16.16) and produces b = A·x. A is the fixed symmetric 16×16 band matrix with diagonal 20, off-diagonals −13, 6, −1 and zeros elsewhere. Each result is rounded and saturated to a 16-bit signed integer, the same format as GSIM's `b_in`. It sits downstream of GSIM as an on-chip residual/self-check path and as a pattern generator for GSIM benches.

---
 rtl/gsim_pkg.sv | 29 ++
 rtl/gsim_round_sat.sv | 36 +++
 rtl/gsim_matvec.sv | 127 ++++++++++++
 tb/tb_gsim_matvec.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/gsim_pkg.sv
// gsim_pkg: shared constants and types for the GSIM banded matrix-vector path.
//   N_VEC        vector / frame length
//   X_W, FRAC_W  Q16.16 input element width and fraction width
//   ACC_W        exact row-sum width (sum of |coef| = 60 < 64 -> 32 + 6 bits)
//   C0..C3       band coefficients: diagonal, then off-diagonals 1..3
//   B_MAX/B_MIN  saturation bounds of the 16-bit signed result
package gsim_pkg;

   localparam int N_VEC  = 16;
   localparam int X_W    = 32;
   localparam int FRAC_W = 16;
   localparam int ACC_W  = 38;
   localparam int B_W    = 16;
   localparam int R_W    = ACC_W - FRAC_W;

   localparam logic signed [ACC_W-1:0] C0 =  38'sd20;
   localparam logic signed [ACC_W-1:0] C1 = -38'sd13;
   localparam logic signed [ACC_W-1:0] C2 =  38'sd6;
   localparam logic signed [ACC_W-1:0] C3 = -38'sd1;

   localparam logic signed [R_W-1:0] B_MAX =  22'sd32767;
   localparam logic signed [R_W-1:0] B_MIN = -22'sd32768;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_t;

endpackage

// File: rtl/gsim_round_sat.sv
// gsim_round_sat: combinational round-half-up, shift and clamp of an exact
// Q16.16 row sum down to a 16-bit signed integer.
//   i_sum  signed ACC_W row sum (Q16.16)
//   o_b    rounded, clamped result
//   o_sat  1 when clamping changed the value
module gsim_round_sat
   import gsim_pkg::*;
(
   input  logic signed [ACC_W-1:0] i_sum,
   output logic        [B_W-1:0]   o_b,
   output logic                    o_sat
);

   localparam logic signed [ACC_W-1:0] HALF = 38'sd32768;

   logic signed [ACC_W-1:0] w_biased;
   logic signed [R_W-1:0]   w_rnd;

   // |S| < 2^37 so adding one half cannot overflow the accumulator width;
   // taking the upper bits is the arithmetic shift by FRAC_W.
   assign w_biased = i_sum + HALF;
   assign w_rnd    = w_biased[ACC_W-1:FRAC_W];

   always_comb begin
      o_b   = w_rnd[B_W-1:0];
      o_sat = 1'b0;
      if (w_rnd > B_MAX) begin
         o_b   = B_MAX[B_W-1:0];
         o_sat = 1'b1;
      end else if (w_rnd < B_MIN) begin
         o_b   = B_MIN[B_W-1:0];
         o_sat = 1'b1;
      end
   end

endmodule

// File: rtl/gsim_matvec.sv
// gsim_matvec: streaming b = A*x for the fixed symmetric 16x16 band matrix
// (20, -13, 6, -1). Consumes Q16.16 x[0..15], emits 16-bit b[0..15].
//   clk, reset_n         clock, async active-low reset
//   in_en, x_in          input element strobe and value (ignored while busy)
//   busy                 high during the 3-cycle flush; upstream holds in_en low
//   out_valid, b_out     one-cycle result pulse and value, ascending i
//   sat                  result was clamped
//
// state | meaning
// RUN   | accept samples; sample k >= 3 schedules b[k-3]
// FLUSH | shift in 3 zeros, scheduling b[13..15]; then window is cleared
module gsim_matvec
   import gsim_pkg::*;
(
   input  logic           clk,
   input  logic           reset_n,
   input  logic           in_en,
   input  logic [X_W-1:0] x_in,
   output logic           busy,
   output logic           out_valid,
   output logic [B_W-1:0] b_out,
   output logic           sat
);

   state_t                  r_state;
   logic [3:0]              r_in_cnt;
   logic [1:0]              r_fl_cnt;
   logic [6:0][X_W-1:0]     r_win;
   logic                    r_pend;
   logic                    r_clr;
   logic                    r_busy;
   logic                    r_valid;
   logic [B_W-1:0]          r_b;
   logic                    r_sat;

   logic signed [ACC_W-1:0] w_e [7];
   logic signed [ACC_W-1:0] w_sum;
   logic        [B_W-1:0]   w_b;
   logic                    w_sat;

   always_comb begin
      for (int i = 0; i < 7; i++) begin
         w_e[i] = {{(ACC_W-X_W){r_win[i][X_W-1]}}, r_win[i]};
      end
   end

   assign w_sum = C0 * w_e[3]
                + C1 * (w_e[2] + w_e[4])
                + C2 * (w_e[1] + w_e[5])
                + C3 * (w_e[0] + w_e[6]);

   gsim_round_sat u_round_sat (
      .i_sum (w_sum),
      .o_b   (w_b),
      .o_sat (w_sat)
   );

   // The window must stay intact after the last flush shift because b[15]
   // is computed from it on the following edge; r_clr defers the clear to
   // that edge, where a new first sample may land in an otherwise zero window.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= RUN;
         r_in_cnt <= '0;
         r_fl_cnt <= '0;
         r_win    <= '0;
         r_pend   <= 1'b0;
         r_clr    <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_pend <= 1'b0;
         case (r_state)
            RUN: begin
               if (in_en) begin
                  r_win  <= r_clr ? {x_in, {(6*X_W){1'b0}}} : {x_in, r_win[6:1]};
                  r_clr  <= 1'b0;
                  r_pend <= (r_in_cnt >= 4'd3);
                  if (r_in_cnt == 4'(N_VEC-1)) begin
                     r_in_cnt <= '0;
                     r_fl_cnt <= '0;
                     r_state  <= FLUSH;
                     r_busy   <= 1'b1;
                  end else begin
                     r_in_cnt <= r_in_cnt + 4'd1;
                  end
               end else if (r_clr) begin
                  r_win <= '0;
                  r_clr <= 1'b0;
               end
            end
            FLUSH: begin
               r_win  <= {{X_W{1'b0}}, r_win[6:1]};
               r_pend <= 1'b1;
               if (r_fl_cnt == 2'd2) begin
                  r_fl_cnt <= '0;
                  r_clr    <= 1'b1;
                  r_busy   <= 1'b0;
                  r_state  <= RUN;
               end else begin
                  r_fl_cnt <= r_fl_cnt + 2'd1;
               end
            end
            default: r_state <= RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_valid <= 1'b0;
         r_b     <= '0;
         r_sat   <= 1'b0;
      end else begin
         r_valid <= r_pend;
         r_sat   <= r_pend & w_sat;
         if (r_pend) begin
            r_b <= w_b;
         end
      end
   end

   assign busy      = r_busy;
   assign out_valid = r_valid;
   assign b_out     = r_b;
   assign sat       = r_sat;

endmodule

// File: tb/tb_gsim_matvec.sv
module tb_gsim_matvec;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_en;
   logic [31:0] x_in;
   logic        busy;
   logic        out_valid;
   logic [15:0] b_out;
   logic        sat;

   int n_chk  = 0;
   int n_pass = 0;

   logic [31:0]       xv [32];
   longint            e_b [32];
   logic              e_sat [32];
   logic signed [15:0] q_b [$];
   logic              q_sat [$];
   int                busy_cnt = 0;
   int                q0;
   int                bz0;

   gsim_matvec dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_en     (in_en),
      .x_in      (x_in),
      .busy      (busy),
      .out_valid (out_valid),
      .b_out     (b_out),
      .sat       (sat)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (reset_n) begin
         if (out_valid) begin
            q_b.push_back(b_out);
            q_sat.push_back(sat);
         end
         if (busy) busy_cnt++;
      end
   end

   task automatic check(input string tag, input longint obs, input longint exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Reference: dense b = A*x with A[i][j] chosen by |i-j|, then round/clamp.
   function automatic void model(input int nfr);
      for (int f = 0; f < nfr; f++) begin
         for (int i = 0; i < 16; i++) begin
            longint s = 0;
            longint r;
            for (int j = 0; j < 16; j++) begin
               int d = (i > j) ? i - j : j - i;
               longint c = (d == 0) ? 20 : (d == 1) ? -13 : (d == 2) ? 6 : (d == 3) ? -1 : 0;
               s += c * longint'($signed(xv[f*16+j]));
            end
            r = (s + 32768) >>> 16;
            e_sat[f*16+i] = 1'b0;
            if (r > 32767) begin r = 32767; e_sat[f*16+i] = 1'b1; end
            else if (r < -32768) begin r = -32768; e_sat[f*16+i] = 1'b1; end
            e_b[f*16+i] = r;
         end
      end
   endfunction

   task automatic send(input logic [31:0] v);
      int guard = 0;
      while (busy && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      in_en = 1'b1;
      x_in  = v;
      @(negedge clk);
      in_en = 1'b0;
   endtask

   task automatic send_frames(input int nfr, input bit gap);
      q0  = q_b.size();
      bz0 = busy_cnt;
      for (int k = 0; k < 16*nfr; k++) begin
         if (gap) repeat ($urandom_range(0, 3)) @(negedge clk);
         send(xv[k]);
      end
   endtask

   task automatic collect(input string tag, input int nfr);
      int guard = 0;
      while (q_b.size() < q0 + 16*nfr && guard < 60) begin
         @(negedge clk);
         guard++;
      end
      repeat (6) @(negedge clk);
      model(nfr);
      check({tag, "_count"}, q_b.size() - q0, 16*nfr);
      check({tag, "_busy"}, busy_cnt - bz0, 3*nfr);
      for (int i = 0; i < 16*nfr; i++) begin
         if (q0 + i < q_b.size()) begin
            check($sformatf("%s_b%0d", tag, i), q_b[q0+i], e_b[i]);
            check($sformatf("%s_sat%0d", tag, i), q_sat[q0+i], e_sat[i]);
         end
      end
   endtask

   task automatic fill(input logic [31:0] v);
      for (int k = 0; k < 32; k++) xv[k] = v;
   endtask

   initial begin : main
      longint c_imp [4]   = '{20, -13, 6, -1};
      longint c_ones [16] = '{12, -1, 5, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 5, -1, 12};

      reset_n = 1'b0;
      in_en   = 1'b0;
      x_in    = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_valid", out_valid, 0);
      check("rst_b", b_out, 0);
      check("rst_sat", sat, 0);
      reset_n = 1'b1;
      @(negedge clk);

      fill(32'h0);
      send_frames(1, 0);
      collect("zero", 1);

      fill(32'h0); xv[0] = 32'h0001_0000;
      send_frames(1, 0);
      collect("imp0", 1);
      for (int i = 0; i < 4; i++) check($sformatf("imp0_const%0d", i), q_b[q0+i], c_imp[i]);

      fill(32'h0); xv[15] = 32'h0001_0000;
      send_frames(1, 0);
      collect("imp15", 1);
      for (int i = 0; i < 4; i++) check($sformatf("imp15_const%0d", i), q_b[q0+15-i], c_imp[i]);

      fill(32'h0001_0000);
      send_frames(1, 0);
      collect("ones", 1);
      for (int i = 0; i < 16; i++) check($sformatf("ones_const%0d", i), q_b[q0+i], c_ones[i]);

      fill(32'h0); xv[0] = 32'h0000_2000;
      send_frames(1, 0);
      collect("rnd", 1);
      check("rnd_const0", q_b[q0], 3);
      check("rnd_const1", q_b[q0+1], -2);

      fill(32'h0); xv[0] = 32'h0700_0000;
      send_frames(1, 0);
      collect("satx", 1);
      check("satx_const0", q_b[q0], 32767);
      check("satx_constsat0", q_sat[q0], 1);
      check("satx_const1", q_b[q0+1], -23296);
      check("satx_const2", q_b[q0+2], 10752);
      check("satx_const3", q_b[q0+3], -1792);

      for (int k = 0; k < 32; k++) xv[k] = 32'($urandom_range(0, 32'h0008_0000)) - 32'h0004_0000;
      send_frames(1, 0);
      collect("rsmall", 1);
      send_frames(1, 1);
      collect("rsmall_gap", 1);

      for (int k = 0; k < 32; k++) xv[k] = $urandom;
      send_frames(1, 1);
      collect("rfull_gap", 1);

      for (int k = 0; k < 32; k++) xv[k] = 32'($urandom_range(0, 32'h0400_0000)) - 32'h0200_0000;
      send_frames(2, 0);
      collect("b2b", 2);
      send_frames(2, 1);
      collect("b2b_gap", 2);

      for (int k = 0; k < 8; k++) send($urandom);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      check("midrst_valid", out_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_b", b_out, 0);
      reset_n = 1'b1;
      @(negedge clk);
      fill(32'h0); xv[0] = 32'h0001_0000;
      send_frames(1, 0);
      collect("midrst_imp", 1);
      for (int i = 0; i < 4; i++) check($sformatf("midrst_const%0d", i), q_b[q0+i], c_imp[i]);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
